mem_fill: RTL and testbench
===========================

MEM_FILL -- requirements
Module: mem_fill

Interface
REQ-001 Parameter ADDR_WIDTH, default 22, SDRAM word address width.
REQ-002 Parameter DATA_WIDTH, default 32, word width; SHALL be a multiple of 8.
REQ-003 Parameter FILL_WORDS, default 96000, number of words filled from address 0; range 1 to 2^ADDR_WIDTH.
REQ-004 Parameter BURST_LENGTH, default 8, words per command burst; must be at least 1.
REQ-005 Parameter AUTO_START, default 1, fill starts automatically after reset when 1.
REQ-006 Parameter VERIFY, default 0, readback-compare pass after fill when 1.
REQ-007 i_Clk  in  1  sole clock; all logic on rising edge.
REQ-008 i_Reset  in  1  synchronous, active-high reset.
REQ-009 i_Start  in  1  one-cycle pulse requesting a fill; ignored while o_Busy.
REQ-010 i_Mode  in  2  pattern select, latched at start.
REQ-011 i_Fill_Value  in  DATA_WIDTH  constant pattern for mode 1, latched at start.
REQ-012 i_Data_Write_Done  in  1  controller accepted current write word.
REQ-013 i_Data_Read_Valid  in  1  i_Data_Read holds word for current o_Data_Address.
REQ-014 i_Data_Read  in  DATA_WIDTH  readback data.
REQ-015 o_Command  out  2  CMD_IDLE / CMD_WRITE / CMD_READ, encodings from the shared SDRAM header.
REQ-016 o_Data_Address  out  ADDR_WIDTH  current word address.
REQ-017 o_Data_Write  out  DATA_WIDTH  current write word.
REQ-018 o_Busy  out  1  fill or verify in progress.
REQ-019 o_SDRAM_Initialized  out  1  fill (and verify, if enabled) complete.
REQ-020 o_Error_Count  out  16  verify mismatches, saturating at 16'hFFFF.
REQ-021 o_First_Error_Address  out  ADDR_WIDTH  address of first mismatch since start.

Function
REQ-022 States: IDLE, WRITE, WGAP, READ, RGAP, DONE.
REQ-023 IDLE->WRITE on i_Start, or in the first cycle after reset release when AUTO_START=1; the transition sets o_Busy=1, o_SDRAM_Initialized=0, address 0, o_Error_Count=0, o_First_Error_Address=0, and latches i_Mode and i_Fill_Value.
REQ-024 Pattern for address A: mode 0 = low byte of A replicated DATA_WIDTH/8 times; mode 1 = latched fill value; mode 2 = A zero-extended or truncated to DATA_WIDTH; mode 3 = 8'hAA replicated if A[0]=0, else 8'h55 replicated.
REQ-025 In WRITE: o_Command=CMD_WRITE and o_Data_Write=pattern(o_Data_Address), both valid in the same cycle.
REQ-026 Each cycle with i_Data_Write_Done=1 in WRITE advances the address by 1 and loads the next pattern in that same edge.
REQ-027 After BURST_LENGTH accepted words, WRITE->WGAP: o_Command=CMD_IDLE for exactly one cycle, then WGAP->WRITE.
REQ-028 Acceptance of word FILL_WORDS-1 ends the fill even mid-burst, so the final burst may be short.
REQ-029 At that point the address wraps to 0; the block enters RGAP if VERIFY=1, else DONE.
REQ-030 READ and RGAP mirror WRITE and WGAP: CMD_READ is issued, i_Data_Read_Valid is the per-word advance, and the same burst and gap rules apply.
REQ-031 Each valid read is compared with pattern(o_Data_Address); on mismatch o_Error_Count increments (saturating), and o_First_Error_Address is captured only when the count was 0.
REQ-032 After the last verified word the address returns to 0 and the state moves to DONE.
REQ-033 DONE: o_Command=CMD_IDLE, o_Busy=0, o_SDRAM_Initialized=1, error outputs held; i_Start re-enters WRITE per REQ-023.
REQ-034 Done/valid strobes are ignored outside WRITE/READ respectively; i_Start while busy is ignored.
REQ-035 Address arithmetic is ADDR_WIDTH-bit modulo; FILL_WORDS=2^ADDR_WIDTH terminates on the wrap to 0.

Reset
REQ-036 i_Reset has priority over every input, including a same-cycle i_Start.
REQ-037 Reset puts the block in IDLE with o_Command=CMD_IDLE, address 0, o_Data_Write 0, o_Busy 0, o_SDRAM_Initialized 0, o_Error_Count 0, o_First_Error_Address 0.
REQ-038 Reset mid-burst aborts the burst with no further CMD_WRITE or CMD_READ; a new fill starts from address 0.

Verification
REQ-039 FILL_WORDS=20, BURST_LENGTH=8, mode 0, done held high -> bursts of 8, 8 and 4 words with one CMD_IDLE gap between bursts; address 19 carries data 32'h13131313; o_SDRAM_Initialized=1 afterwards; address returns to 0.
REQ-040 Mode 3, done held high -> data alternates 32'hAAAAAAAA (even address) and 32'h55555555 (odd address); mode 1 with i_Fill_Value=32'hDEADBEEF -> every word equals DEADBEEF.
REQ-041 Done asserted every third cycle -> address and data change only on done cycles, and the word count is still exact.
REQ-042 VERIFY=1, read model corrupts addresses 5 and 9 -> o_Error_Count=2, o_First_Error_Address=5, done asserted.
REQ-043 Reset at address 10 mid-burst -> next cycle CMD_IDLE, address 0; with AUTO_START=1 the refill restarts from address 0.
REQ-044 i_Start pulsed while busy, and i_Start coincident with reset -> ignored and reset wins respectively; i_Start in DONE -> refill starts and o_SDRAM_Initialized falls.

Source files
------------

// File: rtl/mem_fill.sv
// Fills SDRAM from address 0 with a selectable test pattern in fixed-length bursts,
// optionally reading the image back and counting mismatches.
module mem_fill #(
  parameter int ADDR_WIDTH   = 22,
  parameter int DATA_WIDTH   = 32,
  parameter int FILL_WORDS   = 96000,
  parameter int BURST_LENGTH = 8,
  parameter int AUTO_START   = 1,
  parameter int VERIFY       = 0
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic [1:0]            i_Mode,
  input  logic [DATA_WIDTH-1:0] i_Fill_Value,
  input  logic                  i_Data_Write_Done,
  input  logic                  i_Data_Read_Valid,
  input  logic [DATA_WIDTH-1:0] i_Data_Read,
  output logic [1:0]            o_Command,
  output logic [ADDR_WIDTH-1:0] o_Data_Address,
  output logic [DATA_WIDTH-1:0] o_Data_Write,
  output logic                  o_Busy,
  output logic                  o_SDRAM_Initialized,
  output logic [15:0]           o_Error_Count,
  output logic [ADDR_WIDTH-1:0] o_First_Error_Address
);

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW    = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FILL_WORDS - 1);
  localparam logic [BW-1:0]         LAST_BEAT = BW'(BURST_LENGTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WGAP, S_READ, S_RGAP, S_DONE} state_t;

  state_t                state_q;
  logic [1:0]            cmd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  busy_q;
  logic                  init_q;
  logic [15:0]           errCnt_q;
  logic [ADDR_WIDTH-1:0] firstErr_q;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [BW-1:0]         beat_q;
  logic                  autoPend_q;

  logic [ADDR_WIDTH-1:0] addrInc_d;
  logic [DATA_WIDTH-1:0] patInc_d;
  logic [DATA_WIDTH-1:0] patCur_d;
  logic [DATA_WIDTH-1:0] patStart_d;

  function automatic logic [DATA_WIDTH-1:0] patternFor(input logic [1:0]            mode,
                                                       input logic [DATA_WIDTH-1:0] fill,
                                                       input logic [ADDR_WIDTH-1:0] addr);
    logic [7:0] lowByte;
    lowByte = 8'(addr);
    case (mode)
      2'd0:    patternFor = {BYTES{lowByte}};
      2'd1:    patternFor = fill;
      2'd2:    patternFor = DATA_WIDTH'(addr);
      default: patternFor = addr[0] ? {BYTES{8'h55}} : {BYTES{8'hAA}};
    endcase
  endfunction

  // The start pattern uses the raw inputs because mode and fill value are latched on the same edge.
  always_comb begin
    addrInc_d  = addr_q + 1'b1;
    patInc_d   = patternFor(mode_q, fill_q, addrInc_d);
    patCur_d   = patternFor(mode_q, fill_q, addr_q);
    patStart_d = patternFor(i_Mode, i_Fill_Value, {ADDR_WIDTH{1'b0}});
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      init_q     <= 1'b0;
      errCnt_q   <= '0;
      firstErr_q <= '0;
      mode_q     <= '0;
      fill_q     <= '0;
      beat_q     <= '0;
      autoPend_q <= (AUTO_START != 0);
    end else begin
      autoPend_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_Start || (state_q == S_IDLE && autoPend_q)) begin
            state_q    <= S_WRITE;
            cmd_q      <= CMD_WRITE;
            addr_q     <= '0;
            data_q     <= patStart_d;
            busy_q     <= 1'b1;
            init_q     <= 1'b0;
            errCnt_q   <= '0;
            firstErr_q <= '0;
            mode_q     <= i_Mode;
            fill_q     <= i_Fill_Value;
            beat_q     <= '0;
          end
        end
        S_WRITE: begin
          if (i_Data_Write_Done) begin
            addr_q <= addrInc_d;
            data_q <= patInc_d;
            beat_q <= beat_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
              addr_q <= '0;
              beat_q <= '0;
              cmd_q  <= CMD_IDLE;
              if (VERIFY != 0) begin
                state_q <= S_RGAP;
              end else begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                init_q  <= 1'b1;
              end
            end else if (beat_q == LAST_BEAT) begin
              state_q <= S_WGAP;
              cmd_q   <= CMD_IDLE;
              beat_q  <= '0;
            end
          end
        end
        S_WGAP: begin
          state_q <= S_WRITE;
          cmd_q   <= CMD_WRITE;
        end
        S_RGAP: begin
          state_q <= S_READ;
          cmd_q   <= CMD_READ;
        end
        S_READ: begin
          if (i_Data_Read_Valid) begin
            if (i_Data_Read != patCur_d) begin
              if (errCnt_q != 16'hFFFF) errCnt_q <= errCnt_q + 16'd1;
              if (errCnt_q == 16'd0) firstErr_q <= addr_q;
            end
            addr_q <= addrInc_d;
            beat_q <= beat_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
              addr_q  <= '0;
              beat_q  <= '0;
              cmd_q   <= CMD_IDLE;
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              init_q  <= 1'b1;
            end else if (beat_q == LAST_BEAT) begin
              state_q <= S_RGAP;
              cmd_q   <= CMD_IDLE;
              beat_q  <= '0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          cmd_q   <= CMD_IDLE;
        end
      endcase
    end
  end

  assign o_Command             = cmd_q;
  assign o_Data_Address        = addr_q;
  assign o_Data_Write          = data_q;
  assign o_Busy                = busy_q;
  assign o_SDRAM_Initialized   = init_q;
  assign o_Error_Count         = errCnt_q;
  assign o_First_Error_Address = firstErr_q;

endmodule

// File: tb/tb_mem_fill.sv
// Scoreboard bench for mem_fill: expected word streams are queued per fill and
// matched by a monitor against every accepted write/read.
module tb_mem_fill;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int FW = 20;
  localparam int BL = 8;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [DW-1:0] fillVal;
  logic          wrDone;
  logic          rdValid;
  logic [DW-1:0] rdData;
  logic [1:0]    oCmd;
  logic [AW-1:0] oAddr;
  logic [DW-1:0] oData;
  logic          oBusy;
  logic          oInit;
  logic [15:0]   oErr;
  logic [AW-1:0] oFirst;

  always #5 clk = ~clk;

  mem_fill #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FILL_WORDS(FW),
    .BURST_LENGTH(BL), .AUTO_START(1), .VERIFY(1)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Mode(mode),
    .i_Fill_Value(fillVal), .i_Data_Write_Done(wrDone),
    .i_Data_Read_Valid(rdValid), .i_Data_Read(rdData),
    .o_Command(oCmd), .o_Data_Address(oAddr), .o_Data_Write(oData),
    .o_Busy(oBusy), .o_SDRAM_Initialized(oInit), .o_Error_Count(oErr),
    .o_First_Error_Address(oFirst)
  );

  typedef struct {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
  } exp_t;

  exp_t       sbQ[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         strobeMode = 0;
  bit         strobeEn = 1'b0;
  int         cycleCnt = 0;
  logic [1:0] curMode;
  logic [31:0] curFill;
  logic [255:0] corruptMask;

  // Pattern rules written arithmetically: byte replication is a multiply by 0x01010101.
  function automatic logic [31:0] refPattern(input logic [1:0] m, input logic [31:0] f, input int a);
    case (m)
      2'd0:    return 32'(a % 256) * 32'h01010101;
      2'd1:    return f;
      2'd2:    return 32'(a);
      default: return (a % 2 == 0) ? 32'hAAAAAAAA : 32'h55555555;
    endcase
  endfunction

  always_comb begin
    rdData = refPattern(curMode, curFill, int'(oAddr));
    if (corruptMask[oAddr]) rdData = ~rdData;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic pushFill(input logic [1:0] m, input logic [31:0] f);
    for (int a = 0; a < FW; a++)
      sbQ.push_back('{CMD_WRITE, AW'(a), refPattern(m, f, a), (a % BL == BL - 1) || (a == FW - 1)});
    for (int a = 0; a < FW; a++)
      sbQ.push_back('{CMD_READ, AW'(a), 32'h0, (a % BL == BL - 1) || (a == FW - 1)});
  endtask

  // Strobe driver: held high, every third cycle, or random.
  initial begin : driver
    wrDone  = 1'b0;
    rdValid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cycleCnt++;
      if (!strobeEn) begin
        wrDone  = 1'b0;
        rdValid = 1'b0;
      end else begin
        case (strobeMode)
          0: begin wrDone = 1'b1; rdValid = 1'b1; end
          1: begin wrDone = (cycleCnt % 3 == 0); rdValid = wrDone; end
          default: begin
            wrDone  = 1'($urandom_range(0, 1));
            rdValid = 1'($urandom_range(0, 1));
          end
        endcase
      end
    end
  end

  // Monitor: pops one expected word per accepted transfer and polices the one-cycle gaps.
  initial begin : monitor
    int   gapState;
    exp_t e;
    gapState = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        gapState = 0;
      end else begin
        if (gapState == 1) begin
          checkOutput("gap idle", 32'(oCmd), 32'(CMD_IDLE));
          gapState = 2;
        end else if (gapState == 2) begin
          if (sbQ.size() > 0) checkOutput("burst resume", 32'(oCmd), 32'(sbQ[0].cmd));
          gapState = 0;
        end
        if ((oCmd == CMD_WRITE && wrDone) || (oCmd == CMD_READ && rdValid)) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpected transfer cmd", 32'(oCmd), 32'(CMD_IDLE));
          end else begin
            e = sbQ.pop_front();
            checkOutput("word cmd", 32'(oCmd), 32'(e.cmd));
            checkOutput("word addr", 32'(oAddr), 32'(e.addr));
            if (e.cmd == CMD_WRITE) checkOutput("word data", oData, e.data);
            if (e.last) gapState = 1;
          end
        end
      end
    end
  end

  task automatic waitInit(input string tag);
    int n;
    n = 0;
    while (oInit !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput({tag, " completion"}, 32'(oInit), 32'd1);
  endtask

  task automatic checkFinal(input string tag);
    int expErr;
    int expFirst;
    expErr   = 0;
    expFirst = -1;
    for (int a = 0; a < FW; a++)
      if (corruptMask[a]) begin
        expErr++;
        if (expFirst < 0) expFirst = a;
      end
    if (expFirst < 0) expFirst = 0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput({tag, " init held"}, 32'(oInit), 32'd1);
    checkOutput({tag, " busy"}, 32'(oBusy), 32'd0);
    checkOutput({tag, " cmd"}, 32'(oCmd), 32'(CMD_IDLE));
    checkOutput({tag, " addr"}, 32'(oAddr), 32'd0);
    checkOutput({tag, " errors"}, 32'(oErr), 32'(expErr));
    checkOutput({tag, " first error"}, 32'(oFirst), 32'(expFirst));
    checkOutput({tag, " words left"}, 32'(sbQ.size()), 32'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] m, input logic [31:0] f,
                               input int sm, input logic [255:0] mask);
    curMode     = m;
    curFill     = f;
    corruptMask = mask;
    strobeMode  = sm;
    mode        = m;
    fillVal     = f;
    pushFill(m, f);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    checkOutput({tag, " start busy"}, 32'(oBusy), 32'd1);
    checkOutput({tag, " start init low"}, 32'(oInit), 32'd0);
    checkOutput({tag, " start cmd"}, 32'(oCmd), 32'(CMD_WRITE));
    checkOutput({tag, " start data"}, oData, refPattern(m, f, 0));
    strobeEn = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    mode    = ~m;
    fillVal = ~f;
    start   = 1'b1;
    @(posedge clk);
    #2;
    start   = 1'b0;
    mode    = m;
    fillVal = f;
    waitInit(tag);
    checkFinal(tag);
  endtask

  initial begin : main
    int n;
    logic [255:0] mask;
    rst         = 1'b1;
    start       = 1'b1;
    mode        = 2'd0;
    fillVal     = '0;
    curMode     = 2'd0;
    curFill     = '0;
    corruptMask = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset cmd", 32'(oCmd), 32'(CMD_IDLE));
    checkOutput("reset addr", 32'(oAddr), 32'd0);
    checkOutput("reset data", oData, 32'd0);
    checkOutput("reset busy", 32'(oBusy), 32'd0);
    checkOutput("reset init", 32'(oInit), 32'd0);
    checkOutput("reset errors", 32'(oErr), 32'd0);
    checkOutput("reset first error", 32'(oFirst), 32'd0);
    start      = 1'b0;
    pushFill(2'd0, 32'h0);
    strobeMode = 0;
    strobeEn   = 1'b1;
    rst        = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("auto start busy", 32'(oBusy), 32'd1);
    checkOutput("auto start cmd", 32'(oCmd), 32'(CMD_WRITE));
    waitInit("auto fill");
    checkFinal("auto fill");

    applyStimulus("mode3", 2'd3, 32'h12345678, 0, '0);
    applyStimulus("mode1", 2'd1, 32'hDEADBEEF, 0, '0);
    mask = '0;
    mask[5] = 1'b1;
    mask[9] = 1'b1;
    applyStimulus("verify", 2'd0, 32'h0, 1, mask);
    for (int i = 0; i < 4; i++) begin
      mask = '0;
      mask[FW-1:0] = FW'($urandom) & FW'($urandom);
      applyStimulus("random", 2'($urandom_range(0, 3)), $urandom, 2, mask);
    end

    // Abort a fill mid-burst, then let auto-start refill from address 0.
    curMode     = 2'd2;
    curFill     = '0;
    corruptMask = '0;
    strobeMode  = 0;
    mode        = 2'd2;
    pushFill(2'd2, 32'h0);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    n = 0;
    while (!(oAddr == AW'(10) && oCmd == CMD_WRITE) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("reach addr 10", 32'(oAddr), 32'd10);
    strobeEn = 1'b0;
    wrDone   = 1'b0;
    rdValid  = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("abort cmd", 32'(oCmd), 32'(CMD_IDLE));
    checkOutput("abort addr", 32'(oAddr), 32'd0);
    checkOutput("abort busy", 32'(oBusy), 32'd0);
    sbQ.delete();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("held reset cmd", 32'(oCmd), 32'(CMD_IDLE));
    curMode  = 2'd1;
    curFill  = 32'h0BADF00D;
    mode     = 2'd1;
    fillVal  = 32'h0BADF00D;
    pushFill(2'd1, 32'h0BADF00D);
    strobeEn = 1'b1;
    rst      = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("refill cmd", 32'(oCmd), 32'(CMD_WRITE));
    checkOutput("refill addr", 32'(oAddr), 32'd0);
    checkOutput("refill data", oData, 32'h0BADF00D);
    waitInit("refill");
    checkFinal("refill");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
